// File: rtl/branch_predict_tournament.sv
// Tournament direction predictor: gshare and bimodal tables arbitrated by a PC-indexed chooser.
// Fetch-time indices and the GHR snapshot ride down to M so updates and history repair hit exactly what fetch used.
module branch_predict_tournament #(
    parameter int PHT_DEPTH  = 8,
    parameter int BHT_DEPTH  = 8,
    parameter int CPHT_DEPTH = 8,
    parameter int GHR_LEN    = 8,
    parameter int CTR_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               flushD,
    input  logic               flushE,
    input  logic               flushM,
    input  logic [31:0]        pcF,
    input  logic               branchF,
    input  logic               branchM,
    input  logic               actual_takeM,
    output logic               pred_takeD,
    output logic               mispredictM,
    output logic [GHR_LEN-1:0] ghr_spec
);
    localparam int PHT_N  = 1 << PHT_DEPTH;
    localparam int BHT_N  = 1 << BHT_DEPTH;
    localparam int CPHT_N = 1 << CPHT_DEPTH;
    localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [1:0]       CHO_WEAK = 2'b10;

    typedef struct packed {
        logic                  pred_take;
        logic                  gp;
        logic                  bp;
        logic [PHT_DEPTH-1:0]  gidx;
        logic [BHT_DEPTH-1:0]  bidx;
        logic [CPHT_DEPTH-1:0] cidx;
        logic [GHR_LEN-1:0]    snap;
    } pipe_t;

    logic [CTR_W-1:0]      pht_q  [PHT_N];
    logic [CTR_W-1:0]      bht_q  [BHT_N];
    logic [1:0]            cpht_q [CPHT_N];
    logic [GHR_LEN-1:0]    ghr_q, ghr_d;
    pipe_t                 f_fields, d_q, e_q, m_q;
    logic [PHT_DEPTH-1:0]  ghr_ext;
    logic [PHT_DEPTH-1:0]  gidx_f;
    logic [BHT_DEPTH-1:0]  bidx_f;
    logic [CPHT_DEPTH-1:0] cidx_f;
    logic                  gp_f, bp_f, sel_f, pred_take_f;
    logic                  unused_bits;

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + 1'b1;
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [1:0] cho_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_LEN-1:0] = ghr_q;
    end

    assign gidx_f      = pcF[PHT_DEPTH+1:2] ^ ghr_ext;
    assign bidx_f      = pcF[BHT_DEPTH+1:2];
    assign cidx_f      = pcF[CPHT_DEPTH+1:2];
    // Combinational reads: a same-cycle M write is not visible until the next edge.
    assign gp_f        = pht_q[gidx_f][CTR_W-1];
    assign bp_f        = bht_q[bidx_f][CTR_W-1];
    assign sel_f       = cpht_q[cidx_f][1];
    assign pred_take_f = branchF & (sel_f ? gp_f : bp_f);

    assign f_fields = '{pred_take: pred_take_f, gp: gp_f, bp: bp_f,
                        gidx: gidx_f, bidx: bidx_f, cidx: cidx_f, snap: ghr_q};

    assign mispredictM = branchM & (actual_takeM ^ m_q.pred_take);
    assign pred_takeD  = d_q.pred_take;
    assign ghr_spec    = ghr_q;
    assign unused_bits = ^{pcF, m_q.snap[GHR_LEN-1]};

    // Repair from the M snapshot outranks any speculative shift in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredictM)
            ghr_d = {m_q.snap[GHR_LEN-2:0], actual_takeM};
        else if (branchF && !stallF)
            ghr_d = {ghr_q[GHR_LEN-2:0], pred_take_f};
    end

    always_ff @(posedge clk) begin
        if (rst)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    always_ff @(posedge clk) begin
        if (rst || flushD)
            d_q <= '0;
        else if (!stallD)
            d_q <= f_fields;
    end

    always_ff @(posedge clk) begin
        if (rst || flushE)
            e_q <= '0;
        else
            e_q <= d_q;
    end

    always_ff @(posedge clk) begin
        if (rst || flushM)
            m_q <= '0;
        else
            m_q <= e_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++)
                pht_q[i] <= CTR_WEAK;
        end else if (branchM) begin
            pht_q[m_q.gidx] <= ctr_step(pht_q[m_q.gidx], actual_takeM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++)
                bht_q[i] <= CTR_WEAK;
        end else if (branchM) begin
            bht_q[m_q.bidx] <= ctr_step(bht_q[m_q.bidx], actual_takeM);
        end
    end

    // Chooser only learns when the two components disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CPHT_N; i++)
                cpht_q[i] <= CHO_WEAK;
        end else if (branchM && (m_q.gp != m_q.bp)) begin
            cpht_q[m_q.cidx] <= cho_step(cpht_q[m_q.cidx], m_q.gp == actual_takeM);
        end
    end
endmodule

// File: tb/tb_branch_predict_tournament.sv
// Directed bench for the tournament predictor: a table/queue model checked every cycle plus literal pins.
module tb_branch_predict_tournament;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0, stallD = 1'b0;
    logic        flushD = 1'b0, flushE = 1'b0, flushM = 1'b0;
    logic [31:0] pcF = '0;
    logic        branchF = 1'b0, branchM = 1'b0, actual_takeM = 1'b0;
    logic        pred_takeD, mispredictM;
    logic [7:0]  ghr_spec;
    logic        pred3, misp3;
    logic [7:0]  ghr3;

    always #5 clk = ~clk;

    branch_predict_tournament u_dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .pcF(pcF),
        .branchF(branchF), .branchM(branchM), .actual_takeM(actual_takeM),
        .pred_takeD(pred_takeD), .mispredictM(mispredictM), .ghr_spec(ghr_spec)
    );

    branch_predict_tournament #(.CTR_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .pcF(pcF),
        .branchF(branchF), .branchM(branchM), .actual_takeM(actual_takeM),
        .pred_takeD(pred3), .mispredictM(misp3), .ghr_spec(ghr3)
    );

    // Model: one record per in-flight instruction, tables as plain integer arrays.
    typedef struct {
        bit br; bit pt; bit gp; bit bp;
        int gidx; int bidx; int cidx; int snap;
    } stage_t;

    int     m_pht[256], m_bht[256], m_cht[256];
    int     m_ghr;
    stage_t m_d, m_e, m_m;
    int     checks = 0, errors = 0;
    int     cyc = 0;
    logic   last_misp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v, input bit up, input int mx);
        if (up) return (v >= mx) ? mx : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    task automatic model_step();
        stage_t f, empty;
        bit misp;
        empty = '{default: 0};
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                m_pht[i] = 2; m_bht[i] = 2; m_cht[i] = 2;
            end
            m_ghr = 0; m_d = empty; m_e = empty; m_m = empty;
            return;
        end
        f.br   = branchF;
        f.bidx = (pcF >> 2) & 255;
        f.cidx = f.bidx;
        f.gidx = f.bidx ^ m_ghr;
        f.gp   = m_pht[f.gidx] >= 2;
        f.bp   = m_bht[f.bidx] >= 2;
        f.pt   = branchF && ((m_cht[f.cidx] >= 2) ? f.gp : f.bp);
        f.snap = m_ghr;
        misp = branchM && (actual_takeM != m_m.pt);
        if (branchM) begin
            m_pht[m_m.gidx] = sat(m_pht[m_m.gidx], actual_takeM, 3);
            m_bht[m_m.bidx] = sat(m_bht[m_m.bidx], actual_takeM, 3);
            if (m_m.gp != m_m.bp)
                m_cht[m_m.cidx] = sat(m_cht[m_m.cidx], m_m.gp == actual_takeM, 3);
        end
        if (misp)
            m_ghr = ((m_m.snap << 1) | int'(actual_takeM)) & 255;
        else if (branchF && !stallF)
            m_ghr = ((m_ghr << 1) | int'(f.pt)) & 255;
        m_m = flushM ? empty : m_e;
        m_e = flushE ? empty : m_d;
        if (flushD) m_d = empty;
        else if (!stallD) m_d = f;
    endtask

    // Per-cycle compare at the falling edge, then advance the model to the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            chk("pred_takeD", pred_takeD, m_d.pt);
            chk("mispredictM", mispredictM, branchM && (actual_takeM != m_m.pt));
            chk("ghr_spec", ghr_spec, m_ghr);
        end
        $display("cyc %0d rst=%0b pc=%h bF=%0b bM=%0b act=%0b predD=%0b misp=%0b ghr=%h",
                 cyc, rst, pcF, branchF, branchM, actual_takeM, pred_takeD, mispredictM, ghr_spec);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input bit bf, input int pc, input bit act,
                          input bit sf, input bit sd, input bit fd, input bit fe, input bit fm);
        branchF = bf; pcF = pc; actual_takeM = act;
        stallF = sf; stallD = sd; flushD = fd; flushE = fe; flushM = fm;
        branchM = m_m.br;
    endtask

    task automatic idle(input bit act);
        set_in(0, 0, act, 0, 0, 0, 0, 0);
        tick();
    endtask

    // One branch, fully resolved before the next fetch: fetch, two bubbles, resolve in M.
    task automatic iter(input int pc, input bit outcome);
        set_in(1, pc, 0, 0, 0, 0, 0, 0);
        tick();
        idle(0);
        idle(0);
        set_in(0, 0, outcome, 0, 0, 0, 0, 0);
        #1;
        last_misp = mispredictM;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        branchM = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state and first prediction.
        do_reset();
        chk("reset_predD", pred_takeD, 0);
        chk("reset_misp", mispredictM, 0);
        chk("reset_ghr", ghr_spec, 0);
        set_in(1, 32'h100, 0, 0, 0, 0, 0, 0);
        tick();
        chk("first_predD", pred_takeD, 1);
        chk("first_ghr", ghr_spec, 8'h01);
        idle(0); idle(0); idle(1); idle(0);

        // Not-taken training at 0x200.
        do_reset();
        iter(32'h200, 0);
        iter(32'h200, 0);
        chk("nt_pht", u_dut.pht_q[128], 0);
        chk("nt_bht", u_dut.bht_q[128], 0);
        chk("model_pht_pin", m_pht[128], 0);
        set_in(1, 32'h200, 0, 0, 0, 0, 0, 0);
        tick();
        chk("nt_predD", pred_takeD, 0);
        idle(0); idle(0); idle(0);

        // Repair outranks same-cycle fetch shift.
        do_reset();
        set_in(1, 32'h400, 0, 0, 0, 0, 0, 0); tick();
        set_in(1, 32'h404, 0, 0, 0, 0, 0, 0); tick();
        chk("rep_ghr_pre", ghr_spec, 8'h03);
        idle(0);
        idle(1);
        set_in(1, 32'h408, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rep_misp", mispredictM, 1);
        tick();
        chk("rep_ghr", ghr_spec, 8'h02);

        // Stalled fetch does not shift history.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h500, 0, 1, 1, 0, 1, 0);
            tick();
            chk("stall_ghr", ghr_spec, 8'h00);
        end
        set_in(1, 32'h500, 0, 0, 0, 0, 0, 0);
        tick();
        chk("release_ghr", ghr_spec, 8'h01);
        idle(0); idle(0); idle(1);

        // Alternating pattern: gshare wins the chooser.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            iter(32'h600, (i % 2) == 0);
            if (i >= 30) chk("alt_misp", last_misp, 0);
        end
        chk("alt_chooser", u_dut.cpht_q[128], 3);
        chk("model_cht_pin", m_cht[128], 3);

        // 3-bit counters saturate at both ends.
        do_reset();
        for (int i = 0; i < 10; i++) iter(32'h300, 1);
        chk("ctr3_sat_hi", u_dut3.bht_q[192], 7);
        chk("ctr2_sat_hi", u_dut.bht_q[192], 3);
        for (int i = 0; i < 4; i++) iter(32'h300, 0);
        chk("ctr3_mid", u_dut3.bht_q[192], 3);
        for (int i = 0; i < 4; i++) iter(32'h300, 0);
        chk("ctr3_sat_lo", u_dut3.bht_q[192], 0);

        // Back-to-back branches with stalls and flushes.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            set_in(1, 32'h700 + 4 * (i % 4), (i % 3) == 0,
                   (i % 7) == 3, (i % 7) == 3, (i % 5) == 2, 0, (i % 6) == 4);
            tick();
        end
        for (int i = 0; i < 4; i++) idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
